// File: rtl/fir_par_pkg.sv
// Shared constants and lane-index type for the parallel FIR and its adapters.
//   L      : number of parallel lanes (samples per pair)
//   DW_OUT : default serial sample width
//   lane_t : lane index, even (earlier sample) or odd (later sample)
package fir_par_pkg;

    localparam int unsigned L      = 2;
    localparam int unsigned DW_OUT = 32;

    typedef enum logic {
        LANE_EVEN = 1'b0,
        LANE_ODD  = 1'b1
    } lane_t;

endpackage

// File: rtl/fir_pair_fifo.sv
// Synchronous FIFO holding W-bit pair entries.
//   clk, reset    : clock, synchronous active-low reset
//   push, wr_data : write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   rd_data       : head entry, valid while empty = 0
//   full, empty   : registered occupancy flags
//   level         : number of stored entries
module fir_pair_fifo #(
    parameter  int unsigned W     = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop cancel.
    always_comb begin
        level_nxt = level;
        case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fir_p2s_2to1.sv
// Two-lane parallel to serial converter: buffers {even, odd} pairs and
// emits them one sample per transfer, even lane first.
//   clk, reset                   : clock, synchronous active-low reset
//   in_valid/in_ready            : pair handshake, in_even/in_odd payload
//   out_valid/out_ready          : sample handshake, out_data payload
//   out_phase                    : lane of out_data (0 even, 1 odd)
//   level                        : stored pairs, including a partly emitted one
module fir_p2s_2to1
    import fir_par_pkg::*;
#(
    parameter  int unsigned DW    = DW_OUT,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_even,
    input  logic signed [DW-1:0] in_odd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_phase,
    output logic [LW-1:0]        level
);

    logic [L*DW-1:0] head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            out_xfer;
    lane_t           phase;

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    // Head pair leaves only once its odd sample has been taken.
    assign pop       = out_xfer & (phase == LANE_ODD);
    assign out_phase = phase;

    fir_pair_fifo #(
        .W     (L * DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ({in_odd, in_even}),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Lane select; forced to zero when nothing is valid.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            if (phase == LANE_ODD) out_data = head[L*DW-1:DW];
            else                   out_data = head[DW-1:0];
        end
    end

    // Phase toggles on every accepted sample; reset discards a half-sent pair.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= LANE_EVEN;
        end else if (out_xfer) begin
            phase <= (phase == LANE_EVEN) ? LANE_ODD : LANE_EVEN;
        end
    end

endmodule

// File: tb/tb_fir_p2s_2to1.sv
// Self-checking bench for fir_p2s_2to1 against a sample-queue reference model.
module tb_fir_p2s_2to1;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned VW    = 3 + LW + DW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_even;
    logic signed [DW-1:0] in_odd;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_phase;
    logic [LW-1:0]        level;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: every accepted sample, in emission order, not yet transferred.
    logic [DW-1:0] q[$];
    logic [DW-1:0] emitted[$];

    always #5 clk = ~clk;

    fir_p2s_2to1 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_even   (in_even),
        .in_odd    (in_odd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .level     (level)
    );

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    function automatic logic [VW-1:0] obs_vec();
        return {in_ready, out_valid, out_phase, level, out_data};
    endfunction

    // Expected outputs from the model: pairs = ceil(samples/2), odd count = mid-pair.
    function automatic logic [VW-1:0] exp_vec();
        int n;
        int lv;
        logic [DW-1:0] d;
        n  = q.size();
        lv = (n + 1) / 2;
        d  = (n != 0) ? q[0] : '0;
        return {lv < int'(DEPTH), n != 0, (n % 2) == 1, LW'(lv), d};
    endfunction

    // Drive one cycle of inputs, advance the model, wait for the edge.
    task automatic apply(input logic v, input logic [DW-1:0] e, input logic [DW-1:0] o,
                         input logic rdy);
        bit pop_s;
        bit push_p;
        in_valid  = v;
        in_even   = e;
        in_odd    = o;
        out_ready = rdy;
        if (reset && out_valid && rdy) emitted.push_back(out_data);
        if (!reset) begin
            q.delete();
        end else begin
            pop_s  = (q.size() != 0) && rdy;
            push_p = v && (((q.size() + 1) / 2) < int'(DEPTH));
            if (pop_s) void'(q.pop_front());
            if (push_p) begin
                q.push_back(e);
                q.push_back(o);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [VW-1:0] idle;
        idle      = {1'b1, 1'b0, 1'b0, LW'(0), DW'(0)};
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_even   = '0;
        in_odd    = '0;
        out_ready = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== idle) begin
            n_bad++;
            $display("FAIL reset_hold: observed %h required %h", obs_vec(), idle);
        end
        reset = 1'b1;
        apply(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== idle) begin
            n_bad++;
            $display("FAIL reset_release: observed %h required %h", obs_vec(), idle);
        end
        apply(1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_single();
        logic [VW-1:0] tbl[3];
        tbl[0] = {1'b1, 1'b1, 1'b0, LW'(1), DW'(5)};
        tbl[1] = {1'b1, 1'b1, 1'b1, LW'(1), DW'(-3)};
        tbl[2] = {1'b1, 1'b0, 1'b0, LW'(0), DW'(0)};
        @(negedge clk);
        n_cmp++;
        if (level !== LW'(0)) begin
            n_bad++;
            $display("FAIL single_level0: observed %0d required 0", level);
        end
        apply(1'b1, DW'(5), DW'(-3), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== tbl[i]) begin
                n_bad++;
                $display("FAIL single_step%0d: observed %h required %h", i, obs_vec(), tbl[i]);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_model%0d: observed %h required %h", i, obs_vec(), exp_vec());
            end
            apply(1'b0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_fill();
        logic [VW-1:0] full_v;
        full_v = {1'b0, 1'b1, 1'b0, LW'(4), DW'(1)};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fill_push%0d: observed %h required %h", k, obs_vec(), exp_vec());
            end
            apply(1'b1, DW'(2 * k + 1), DW'(2 * k + 2), 1'b0);
        end
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== full_v) begin
            n_bad++;
            $display("FAIL fill_full: observed %h required %h", obs_vec(), full_v);
        end
        apply(1'b1, DW'(9), DW'(10), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== full_v) begin
            n_bad++;
            $display("FAIL fill_fifth_rejected: observed %h required %h", obs_vec(), full_v);
        end
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            n_cmp++;
            if (out_data !== DW'(k + 1) || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_drain%0d: observed %0d/%b required %0d/1", k, out_data,
                         out_valid, k + 1);
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fill_model%0d: observed %h required %h", k, obs_vec(), exp_vec());
            end
            apply(1'b0, '0, '0, 1'b1);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || level !== LW'(0)) begin
            n_bad++;
            $display("FAIL fill_empty: observed valid %b level %0d required 0 0", out_valid, level);
        end
        apply(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_stream();
        int acc = 0;
        int xfer = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stream_c%0d: observed %h required %h", c, obs_vec(), exp_vec());
            end
            if (c >= 20) begin
                if (in_ready) acc++;
                if (out_valid) xfer++;
            end
            apply(1'b1, DW'($urandom), DW'($urandom), 1'b1);
        end
        n_cmp++;
        if (xfer != 40) begin
            n_bad++;
            $display("FAIL stream_rate: observed %0d samples required 40", xfer);
        end
        n_cmp++;
        if (acc < 19 || acc > 21) begin
            n_bad++;
            $display("FAIL stream_accept: observed %0d pairs required 19..21", acc);
        end
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stream_drain%0d: observed %h required %h", c, obs_vec(), exp_vec());
            end
            apply(1'b0, '0, '0, 1'b1);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_drain_budget: observed %0d left required 0", q.size());
        end
    endtask

    task automatic test_random();
        int pushed = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        logic [DW:0] held;
        logic [VW-1:0] e;
        logic v;
        logic rdy;
        held = '0;
        while (pushed < 1000 && cyc < 20000) begin
            @(negedge clk);
            e = exp_vec();
            n_cmp++;
            if (obs_vec() !== e) begin
                n_bad++;
                $display("FAIL random_c%0d: observed %h required %h", cyc, obs_vec(), e);
            end
            if (stalled) begin
                n_cmp++;
                if ({out_phase, out_data} !== held) begin
                    n_bad++;
                    $display("FAIL random_stall_hold%0d: observed %h required %h", cyc,
                             {out_phase, out_data}, held);
                end
            end
            v   = 1'($urandom_range(0, 1));
            rdy = 1'($urandom_range(0, 1));
            if (v && (((q.size() + 1) / 2) < int'(DEPTH))) pushed++;
            stalled = (q.size() != 0) && !rdy;
            held    = {e[DW+LW], e[DW-1:0]};
            apply(v, DW'($urandom), DW'($urandom), rdy);
            cyc++;
        end
        n_cmp++;
        if (pushed != 1000) begin
            n_bad++;
            $display("FAIL random_budget: observed %0d pairs required 1000", pushed);
        end
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_drain%0d: observed %h required %h", c, obs_vec(), exp_vec());
            end
            apply(1'b0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        logic [VW-1:0] idle;
        int hits = 0;
        idle = {1'b1, 1'b0, 1'b0, LW'(0), DW'(0)};
        emitted.delete();
        @(negedge clk);
        apply(1'b1, DW'(10), DW'(20), 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_data !== DW'(10) || out_phase !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_even: observed %0d/%b required 10/0", out_data, out_phase);
        end
        apply(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_data !== DW'(20) || out_phase !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_odd_pending: observed %0d/%b required 20/1", out_data, out_phase);
        end
        reset = 1'b0;
        apply(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (obs_vec() !== idle) begin
            n_bad++;
            $display("FAIL mid_flush: observed %h required %h", obs_vec(), idle);
        end
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mid_after%0d: observed %h required %h", c, obs_vec(), exp_vec());
            end
            apply(1'b0, '0, '0, 1'b1);
        end
        foreach (emitted[i]) if (emitted[i] == DW'(20)) hits++;
        n_cmp++;
        if (hits != 0 || emitted.size() != 1) begin
            n_bad++;
            $display("FAIL mid_no_odd: observed %0d emitted with %0d of 20 required 1 with 0",
                     emitted.size(), hits);
        end
    endtask

    task automatic test_impulse();
        logic [DW-1:0] pe[4];
        logic [DW-1:0] po[4];
        int idx = 0;
        bit acc;
        logic v;
        pe[0] = DW'(1);
        po[0] = '0;
        for (int i = 1; i < 4; i++) begin
            pe[i] = '0;
            po[i] = '0;
        end
        emitted.delete();
        for (int c = 0; c < 40 && (idx < 4 || q.size() != 0); c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL impulse_c%0d: observed %h required %h", c, obs_vec(), exp_vec());
            end
            v   = (idx < 4);
            acc = v && (((q.size() + 1) / 2) < int'(DEPTH));
            apply(v, v ? pe[idx] : '0, v ? po[idx] : '0, 1'b1);
            if (acc) idx++;
        end
        n_cmp++;
        if (emitted.size() != 8) begin
            n_bad++;
            $display("FAIL impulse_count: observed %0d samples required 8", emitted.size());
        end
        for (int i = 0; i < 8 && i < emitted.size(); i++) begin
            n_cmp++;
            if (emitted[i] !== ((i == 0) ? DW'(1) : DW'(0))) begin
                n_bad++;
                $display("FAIL impulse_s%0d: observed %0d required %0d", i, emitted[i],
                         (i == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_random();
        test_reset_mid();
        test_impulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
